// File: rtl/fetch_pkg.sv
// Shared definitions for the tile fetch address generator: FSM states,
// mode encodings and config clamping.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_t;

  localparam logic MODE_LINEAR  = 1'b0;
  localparam logic MODE_STRIDED = 1'b1;

  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_addr_accum.sv
// Registered beat address accumulator: loads the tile base, then steps by
// 1 (LINEAR) or ROW_STRIDE (STRIDED) on each advance.
module fetch_addr_accum
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ROW_STRIDE = 768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  advance,
  input  logic                  stride_sel,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] step;

  always_comb begin
    step = ADDR_WIDTH'(1);
    if (stride_sel == MODE_STRIDED) step = ADDR_WIDTH'(ROW_STRIDE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       addr <= '0;
    else if (load)    addr <= load_val;
    else if (advance) addr <= addr + step;
  end

endmodule

// File: rtl/tile_fetch_addr_gen.sv
// BRAM tile fetch address generator: one read address per accepted beat,
// linear or strided, with tile pointer wrap and deferred pointer reset.
module tile_fetch_addr_gen
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned BEAT_WIDTH  = 6,
  parameter int unsigned TILE_WIDTH  = 9,
  parameter int unsigned BASE_OFFSET = 0,
  parameter int unsigned ROW_STRIDE  = 768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_fetch,
  input  logic                  reset_ptr,
  input  logic                  mode,
  input  logic [BEAT_WIDTH-1:0] cfg_beats,
  input  logic [TILE_WIDTH-1:0] cfg_num_tiles,
  input  logic                  fetch_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  busy,
  output logic                  fetch_done,
  output logic [TILE_WIDTH-1:0] tile_idx,
  output logic                  last_tile
);

  fetch_state_t state, state_nxt;

  logic                  mode_lat;
  logic [BEAT_WIDTH-1:0] beats_lat;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [TILE_WIDTH-1:0] ntiles_lat;
  logic [ADDR_WIDTH-1:0] lin_acc;
  logic                  ptr_pending;
  logic                  start_acc;
  logic                  beat_fire;
  logic                  last_beat;
  logic                  ptr_clear;
  logic [ADDR_WIDTH-1:0] tile_base;

  assign start_acc = (state == ST_IDLE) && start_fetch;
  assign beat_fire = bram_en && fetch_ready;
  assign last_beat = (beat_cnt == beats_lat - BEAT_WIDTH'(1));
  assign last_tile = (ntiles_lat != '0) && (tile_idx == ntiles_lat - TILE_WIDTH'(1));
  assign ptr_clear = reset_ptr || ptr_pending || last_tile;

  // lin_acc tracks tile_idx*beats without a multiplier
  always_comb begin
    tile_base = ADDR_WIDTH'(BASE_OFFSET) + lin_acc;
    if (mode == MODE_STRIDED) tile_base = ADDR_WIDTH'(BASE_OFFSET) + ADDR_WIDTH'(tile_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_fetch) state_nxt = ST_FETCH;
      ST_FETCH: if (beat_fire && last_beat) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    fetch_done = 1'b0;
    case (state)
      ST_FETCH: busy = 1'b1;
      ST_DONE: begin
        busy       = 1'b1;
        fetch_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_lat   <= MODE_LINEAR;
      beats_lat  <= BEAT_WIDTH'(1);
      ntiles_lat <= '0;
      beat_cnt   <= '0;
      bram_en    <= 1'b0;
    end else if (start_acc) begin
      mode_lat   <= mode;
      beats_lat  <= BEAT_WIDTH'(clamp_min1(32'(cfg_beats)));
      ntiles_lat <= TILE_WIDTH'(clamp_min1(32'(cfg_num_tiles)));
      beat_cnt   <= '0;
      bram_en    <= 1'b1;
    end else if (beat_fire) begin
      if (last_beat) bram_en  <= 1'b0;
      else           beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
    end
  end

  // reset_ptr during FETCH is deferred to DONE so the tile finishes intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_idx    <= '0;
      lin_acc     <= '0;
      ptr_pending <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: if (reset_ptr) ptr_pending <= 1'b1;
        ST_DONE: begin
          ptr_pending <= 1'b0;
          if (ptr_clear) begin
            tile_idx <= '0;
            lin_acc  <= '0;
          end else begin
            tile_idx <= tile_idx + TILE_WIDTH'(1);
            lin_acc  <= lin_acc + ADDR_WIDTH'(beats_lat);
          end
        end
        default: begin
          if (reset_ptr) begin
            tile_idx <= '0;
            lin_acc  <= '0;
          end
        end
      endcase
    end
  end

  fetch_addr_accum #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROW_STRIDE(ROW_STRIDE)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start_acc),
    .load_val  (tile_base),
    .advance   (beat_fire && !last_beat),
    .stride_sel(mode_lat),
    .addr      (bram_addr)
  );

endmodule

// File: tb/tb_tile_fetch_addr_gen.sv
// Self-checking bench for tile_fetch_addr_gen against a tile-level
// reference model (address = base + k*step, pointer/offset bookkeeping).
module tb_tile_fetch_addr_gen;

  localparam int AW = 16;
  localparam int BW = 6;
  localparam int TW = 9;
  localparam int unsigned BASE   = 4096;
  localparam int unsigned STRIDE = 768;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_fetch;
  logic          reset_ptr;
  logic          mode;
  logic [BW-1:0] cfg_beats;
  logic [TW-1:0] cfg_num_tiles;
  logic          fetch_ready;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          busy;
  logic          fetch_done;
  logic [TW-1:0] tile_idx;
  logic          last_tile;

  always #5 clk = ~clk;

  tile_fetch_addr_gen #(
    .ADDR_WIDTH (AW),
    .BEAT_WIDTH (BW),
    .TILE_WIDTH (TW),
    .BASE_OFFSET(BASE),
    .ROW_STRIDE (STRIDE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_fetch  (start_fetch),
    .reset_ptr    (reset_ptr),
    .mode         (mode),
    .cfg_beats    (cfg_beats),
    .cfg_num_tiles(cfg_num_tiles),
    .fetch_ready  (fetch_ready),
    .bram_addr    (bram_addr),
    .bram_en      (bram_en),
    .busy         (busy),
    .fetch_done   (fetch_done),
    .tile_idx     (tile_idx),
    .last_tile    (last_tile)
  );

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int unsigned   m_tile = 0;
  int unsigned   m_lin  = 0;
  int unsigned   m_n    = 0;
  bit            m_pend = 0;
  logic [AW-1:0] m_last_addr = '0;

  function automatic logic [AW-1:0] exp_addr(input int unsigned off, input int unsigned k,
                                             input bit md);
    int unsigned step;
    step = md ? STRIDE : 1;
    return AW'(BASE + off + k * step);
  endfunction

  function automatic logic exp_last();
    return (m_n != 0) && (m_tile == m_n - 1);
  endfunction

  function automatic void model_reset();
    m_tile = 0; m_lin = 0; m_n = 0; m_pend = 0; m_last_addr = '0;
  endfunction

  // One tile, starting from an IDLE negedge and ending at the following IDLE negedge.
  // stall_kind: 0 always ready, 1 random ready, 2 two stall cycles on beat 1.
  task automatic do_tile(input int beats_cfg, input int n_cfg, input bit md, input int stall_kind,
                         input int rp_fetch_cyc, input bit rp_done, input bit start_noise);
    int            beats;
    int            n;
    int unsigned   off;
    int            k;
    int            cyc;
    int            hold;
    logic [AW-1:0] ea;
    beats = (beats_cfg == 0) ? 1 : beats_cfg;
    n     = (n_cfg == 0) ? 1 : n_cfg;
    off   = md ? m_tile : m_lin;
    k = 0; cyc = 0; hold = 0;

    start_fetch   = 1'b1;
    mode          = md;
    cfg_beats     = BW'(beats_cfg);
    cfg_num_tiles = TW'(n_cfg);
    fetch_ready   = 1'b1;
    @(negedge clk);
    start_fetch = 1'b0;
    m_n = n;

    while (k < beats && cyc < 300) begin
      ea = exp_addr(off, k, md);
      vectors++;
      if (bram_en !== 1'b1 || bram_addr !== ea) begin
        errors++;
        $display("FAIL beat%0d_addr: en=%b addr=%0d, required en=1 addr=%0d", k, bram_en, bram_addr, ea);
      end
      vectors++;
      if (busy !== 1'b1 || fetch_done !== 1'b0 || tile_idx !== TW'(m_tile) || last_tile !== exp_last()) begin
        errors++;
        $display("FAIL fetch_status: busy=%b done=%b tile=%0d last=%b, required 1 0 %0d %b",
                 busy, fetch_done, tile_idx, last_tile, m_tile, exp_last());
      end
      case (stall_kind)
        1:       fetch_ready = ($urandom_range(0, 3) != 0);
        2:       fetch_ready = !(k == 1 && hold < 2);
        default: fetch_ready = 1'b1;
      endcase
      if (!fetch_ready && k == 1) hold++;
      if (cyc == rp_fetch_cyc) begin
        reset_ptr = 1'b1;
        m_pend = 1;
      end else begin
        reset_ptr = 1'b0;
      end
      start_fetch = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (fetch_ready) k++;
      cyc++;
    end
    reset_ptr = 1'b0;
    if (cyc >= 300) begin
      vectors++;
      errors++;
      $display("FAIL fetch_timeout: beats issued=%0d, required %0d", k, beats);
    end

    ea = exp_addr(off, beats - 1, md);
    m_last_addr = ea;
    vectors++;
    if (fetch_done !== 1'b1 || busy !== 1'b1 || bram_en !== 1'b0 || bram_addr !== ea) begin
      errors++;
      $display("FAIL done_cycle: done=%b busy=%b en=%b addr=%0d, required 1 1 0 %0d",
               fetch_done, busy, bram_en, bram_addr, ea);
    end
    reset_ptr   = rp_done;
    start_fetch = start_noise;
    fetch_ready = 1'($urandom_range(0, 1));
    if (m_pend || rp_done || m_tile == m_n - 1) begin
      m_tile = 0;
      m_lin  = 0;
    end else begin
      m_tile = (m_tile + 1) % (1 << TW);
      m_lin  = m_lin + beats;
    end
    m_pend = 0;
    @(negedge clk);
    reset_ptr   = 1'b0;
    start_fetch = 1'b0;

    vectors++;
    if (busy !== 1'b0 || fetch_done !== 1'b0 || bram_en !== 1'b0 || bram_addr !== m_last_addr) begin
      errors++;
      $display("FAIL idle_after: busy=%b done=%b en=%b addr=%0d, required 0 0 0 %0d",
               busy, fetch_done, bram_en, bram_addr, m_last_addr);
    end
    vectors++;
    if (tile_idx !== TW'(m_tile) || last_tile !== exp_last()) begin
      errors++;
      $display("FAIL tile_ptr: tile=%0d last=%b, required %0d %b", tile_idx, last_tile, m_tile, exp_last());
    end
  endtask

  task automatic pulse_reset_ptr_idle();
    reset_ptr = 1'b1;
    @(negedge clk);
    reset_ptr = 1'b0;
    m_tile = 0;
    m_lin  = 0;
    vectors++;
    if (tile_idx !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ptr_idle: tile=%0d busy=%b, required 0 0", tile_idx, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_fetch = 1'b0; reset_ptr = 1'b0; mode = 1'b0;
    cfg_beats = '0; cfg_num_tiles = '0; fetch_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (bram_addr !== '0 || bram_en !== 1'b0 || busy !== 1'b0 || fetch_done !== 1'b0 ||
        tile_idx !== '0 || last_tile !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: addr=%0d en=%b busy=%b done=%b tile=%0d last=%b, required all 0",
               bram_addr, bram_en, busy, fetch_done, tile_idx, last_tile);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_linear();
    for (int t = 0; t < 5; t++) do_tile(2, 16, 1'b0, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_strided();
    do_tile(3, 16, 1'b1, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_tile(4, 16, 1'b0, 2, -1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    pulse_reset_ptr_idle();
    for (int t = 0; t < 4; t++) do_tile(2, 3, 1'b0, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_ptr();
    pulse_reset_ptr_idle();
    do_tile(3, 8, 1'b0, 0, -1, 1'b0, 1'b0);
    do_tile(3, 8, 1'b0, 0, -1, 1'b0, 1'b0);
    do_tile(3, 8, 1'b0, 0, 1, 1'b0, 1'b0);
    do_tile(2, 8, 1'b0, 0, -1, 1'b0, 1'b0);
    do_tile(2, 8, 1'b0, 0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    do_tile(2, 8, 1'b0, 0, -1, 1'b0, 1'b0);
    start_fetch = 1'b1; mode = 1'b0; cfg_beats = BW'(5); cfg_num_tiles = TW'(8); fetch_ready = 1'b1;
    @(negedge clk);
    start_fetch = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (bram_en !== 1'b0 || busy !== 1'b0 || fetch_done !== 1'b0 || tile_idx !== '0 || bram_addr !== '0) begin
      errors++;
      $display("FAIL async_abort: en=%b busy=%b done=%b tile=%0d addr=%0d, required all 0",
               bram_en, busy, fetch_done, tile_idx, bram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (fetch_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle%0d: done=%b busy=%b, required 0 0", c, fetch_done, busy);
      end
    end
    do_tile(3, 8, 1'b0, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      do_tile(int'($urandom_range(0, 8)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
              ($urandom_range(0, 9) == 0), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_strided();
    test_backpressure();
    test_wrap();
    test_reset_ptr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tile_fetch_addr_gen.md
Name: tile_fetch_addr_gen

Overview:
Next-generation BRAM tile fetch address generator for the arbiter fetch path. It issues one BRAM read address per beat for a tile, in one of two runtime-selectable modes:
- LINEAR: contiguous tile storage.
- STRIDED: column walk over a row-major matrix, for transposed reads.
It adds runtime beat/tile counts, downstream backpressure, tile-pointer wrap and a deferred pointer reset. Addresses are computed incrementally, with no multipliers.

Parameters:
- ADDR_WIDTH, 16, BRAM address width.
- BEAT_WIDTH, 6, width of beat counter and cfg_beats (max 63 beats/tile).
- TILE_WIDTH, 9, width of tile pointer and cfg_num_tiles.
- BASE_OFFSET, 0, region start address added to every address.
- ROW_STRIDE, 768, address step between beats in STRIDED mode (matrix columns).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_fetch  in  1  request one tile fetch; accepted only in IDLE
- reset_ptr  in  1  pulse: return tile pointer to 0
- mode  in  1  0 = LINEAR, 1 = STRIDED; sampled on accepted start
- cfg_beats  in  BEAT_WIDTH  beats per tile; sampled on start; 0 treated as 1
- cfg_num_tiles  in  TILE_WIDTH  tiles before pointer wrap; sampled on start; 0 treated as 1
- fetch_ready  in  1  downstream/BRAM accepts a beat this cycle
- bram_addr  out  ADDR_WIDTH  read address
- bram_en  out  1  read enable; a beat is issued when bram_en && fetch_ready
- busy  out  1  high in FETCH and DONE
- fetch_done  out  1  one-cycle pulse at tile end
- tile_idx  out  TILE_WIDTH  current tile pointer
- last_tile  out  1  tile_idx == cfg_num_tiles_latched-1

Behaviour:
- Reset values: state IDLE; bram_addr 0; bram_en 0; busy 0; fetch_done 0; tile_idx 0; last_tile 0; pending reset 0.
- States and transitions:
  - IDLE -> FETCH on start_fetch. Latch mode, cfg_beats, cfg_num_tiles and tile_base.
  - FETCH -> DONE when the final beat is issued.
  - DONE -> IDLE unconditionally.
  - start_fetch in FETCH or DONE is ignored (not queued).
- tile_base at start:
  - LINEAR: BASE_OFFSET + tile_idx*beats, held in a running accumulator that advances by beats per completed tile and clears on pointer reset/wrap.
  - STRIDED: BASE_OFFSET + tile_idx.
- Beat address:
  - Beat 0 = tile_base.
  - Each issued beat adds 1 (LINEAR) or ROW_STRIDE (STRIDED).
  - All sums are modulo 2^ADDR_WIDTH.
- Latency: start_fetch high at cycle N → bram_en=1 with the beat-0 address at N+1. With fetch_ready held high, the last beat is at N+beats, fetch_done at N+beats+1, and the next start is accepted at N+beats+2.
- bram_addr and bram_en are registered. When fetch_ready=0, bram_addr and bram_en hold and no beat is counted.
- Outside FETCH, bram_en=0 and bram_addr holds its last value.
- Tile pointer:
  - Increments in DONE.
  - Wraps to 0 when the completed tile was cfg_num_tiles-1.
- reset_ptr:
  - In IDLE or DONE: tile_idx clears the next cycle and overrides the DONE increment.
  - In FETCH: sets the pending flag and the current tile completes unchanged. At DONE, tile_idx becomes 0 instead of incrementing and the flag clears.
- Asynchronous reset mid-FETCH aborts the tile immediately: no fetch_done, all reset values restored.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding (IDLE, FETCH, DONE);
  - mode constants MODE_LINEAR=0, MODE_STRIDED=1;
  - helper function for clamping zero config values to 1.
- One sub-module, fetch_addr_accum: registered base/beat address accumulator with load, step-select (1 / ROW_STRIDE) and advance enable.
- The top level holds the FSM, counters and pointer logic.

Test Plan:
- LINEAR, BASE_OFFSET=0, cfg_beats=2, three starts with ready=1 → addresses 0,1 / 2,3 / 4,5. fetch_done at N+3 after each start; tile_idx 0→1→2→3.
- STRIDED, BASE_OFFSET=4096, ROW_STRIDE=768, cfg_beats=3, tile_idx=5 → addresses 4101, 4869, 5637.
- Backpressure: LINEAR, cfg_beats=4, fetch_ready low for 2 cycles after beat 1 → address 1 held with bram_en=1 for 3 cycles; 4 beats total; fetch_done delayed by 2 cycles.
- Wrap: cfg_num_tiles=3, four tiles → tile_idx sequence 0,1,2,0; last_tile high during tile 2; fourth tile starts at BASE_OFFSET.
- reset_ptr during FETCH of tile 2 → tile completes with its addresses; tile_idx=0 after DONE. reset_ptr and DONE in the same cycle → tile_idx=0.
- rst_n asserted mid-FETCH, then start again → no fetch_done; restart at tile 0 address; start_fetch pulses during FETCH produce no extra tile.
